dest_track_pipe: RTL and testbench

- Keeps the in-flight register-write records for the 5-stage pipeline: per stage, a write-enable flag and a destination register.
- Drives the `write_*`/`waddr_*` ports that the stall/conflict detector compares against the rs/rt fields of the decoding instruction.
- Consumes that detector's stall back: on a stall it injects a bubble, and it also handles branch/jump annulment.
- Counts stall and bubble cycles, and flags an illegal stall that outlasts the pipeline depth.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/sat_counter.sv | 36 +++
 rtl/dest_track_pipe.sv | 116 +++++++++++
 tb/tb_dest_track_pipe.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the destination-tracking pipeline records.
package pipe_pkg;

  localparam int PIPE_REG_AW = 5;

  typedef struct packed {
    logic                   wen;
    logic [PIPE_REG_AW-1:0] waddr;
  } wr_rec_t;

  localparam wr_rec_t WR_BUBBLE = '{wen: 1'b0, waddr: '0};

  localparam logic [PIPE_REG_AW-1:0] ZERO_REG = '0;

  // Builds a record, dropping the write flag for register 0 since it is hardwired.
  function automatic wr_rec_t makeRec(input logic wen, input logic [PIPE_REG_AW-1:0] waddr);
    wr_rec_t rec;
    rec.wen   = wen && (waddr != ZERO_REG);
    rec.waddr = waddr;
    return rec;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones and has a synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority, otherwise step unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/dest_track_pipe.sv
// In-flight register-write tracker for the ID/EXE/MEM slots, with stall
// bubbles, flush annulment, performance counters and a runaway-stall flag.
module dest_track_pipe
  import pipe_pkg::*;
#(
  parameter int REG_AW    = PIPE_REG_AW,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [REG_AW-1:0] issue_waddr,
  input  logic              stall,
  input  logic              flush,
  output logic              write_ID,
  output logic              write_EXE,
  output logic              write_MEM,
  output logic [REG_AW-1:0] waddr_ID,
  output logic [REG_AW-1:0] waddr_EXE,
  output logic [REG_AW-1:0] waddr_MEM,
  output logic              wb_wen,
  output logic [REG_AW-1:0] wb_waddr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic              stall_err
);

  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

  wr_rec_t id_q, exe_q, mem_q, wb_q;
  wr_rec_t id_d;
  logic    stall_err_q, stall_err_d;
  logic    bubble_inc;
  logic [RUN_W-1:0] run_cnt;

  // An issue that is dropped because of a stall or flush is a counted bubble.
  assign bubble_inc = issue_valid && (flush || stall);

  // ID-slot entry: flush and stall both force a bubble, else take the issue.
  always_comb begin
    id_d = WR_BUBBLE;
    if (!flush && !stall && issue_valid) begin
      id_d = makeRec(issue_wen, issue_waddr);
    end
  end

  // Shift chain: every edge each record moves one slot toward writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q  <= WR_BUBBLE;
      exe_q <= WR_BUBBLE;
      mem_q <= WR_BUBBLE;
      wb_q  <= WR_BUBBLE;
    end else begin
      wb_q  <= mem_q;
      mem_q <= exe_q;
      exe_q <= id_q;
      id_q  <= id_d;
    end
  end

  // The flag rises on the edge that takes the run count past MAX_STALL.
  always_comb begin
    stall_err_d = stall_err_q;
    if (stall && (run_cnt == RUN_LIMIT)) begin
      stall_err_d = 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_err_q <= 1'b0;
    end else begin
      stall_err_q <= stall_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clr   (1'b0),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bubble_inc),
    .clr   (1'b0),
    .q     (bubble_cnt)
  );

  sat_counter #(.W(RUN_W)) u_run_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .clr   (!stall),
    .q     (run_cnt)
  );

  assign write_ID  = id_q.wen;
  assign waddr_ID  = id_q.waddr;
  assign write_EXE = exe_q.wen;
  assign waddr_EXE = exe_q.waddr;
  assign write_MEM = mem_q.wen;
  assign waddr_MEM = mem_q.waddr;
  assign wb_wen    = wb_q.wen;
  assign wb_waddr  = wb_q.waddr;
  assign stall_err = stall_err_q;

endmodule

// File: tb/tb_dest_track_pipe.sv
// Directed self-checking bench for dest_track_pipe.
module tb_dest_track_pipe;

  logic        clk;
  logic        rst_n;
  logic        issueValid;
  logic        issueWen;
  logic [4:0]  issueWaddr;
  logic        stallIn;
  logic        flushIn;
  logic        writeId, writeExe, writeMem;
  logic [4:0]  waddrId, waddrExe, waddrMem;
  logic        wbWen;
  logic [4:0]  wbWaddr;
  logic [15:0] stallCnt;
  logic [15:0] bubbleCnt;
  logic        stallErr;

  int checkCount;
  int passCount;

  dest_track_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issueValid),
    .issue_wen   (issueWen),
    .issue_waddr (issueWaddr),
    .stall       (stallIn),
    .flush       (flushIn),
    .write_ID    (writeId),
    .write_EXE   (writeExe),
    .write_MEM   (writeMem),
    .waddr_ID    (waddrId),
    .waddr_EXE   (waddrExe),
    .waddr_MEM   (waddrMem),
    .wb_wen      (wbWen),
    .wb_waddr    (wbWaddr),
    .stall_cnt   (stallCnt),
    .bubble_cnt  (bubbleCnt),
    .stall_err   (stallErr)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [4:0] a,
                               input logic s, input logic f);
    issueValid = v;
    issueWen   = w;
    issueWaddr = a;
    stallIn    = s;
    flushIn    = f;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wID"},   {31'd0, writeId},  32'd0);
    checkOutput({tag, "_wEXE"},  {31'd0, writeExe}, 32'd0);
    checkOutput({tag, "_wMEM"},  {31'd0, writeMem}, 32'd0);
    checkOutput({tag, "_aID"},   {27'd0, waddrId},  32'd0);
    checkOutput({tag, "_aEXE"},  {27'd0, waddrExe}, 32'd0);
    checkOutput({tag, "_aMEM"},  {27'd0, waddrMem}, 32'd0);
    checkOutput({tag, "_wbWen"}, {31'd0, wbWen},    32'd0);
    checkOutput({tag, "_wbA"},   {27'd0, wbWaddr},  32'd0);
    checkOutput({tag, "_sCnt"},  {16'd0, stallCnt}, 32'd0);
    checkOutput({tag, "_bCnt"},  {16'd0, bubbleCnt}, 32'd0);
    checkOutput({tag, "_err"},   {31'd0, stallErr}, 32'd0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #3;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Issue $5 and follow it to writeback.
    applyStimulus(1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("r5_wID", {31'd0, writeId}, 32'd1);
    checkOutput("r5_aID", {27'd0, waddrId}, 32'd5);
    tick();
    checkOutput("r5_wEXE", {31'd0, writeExe}, 32'd1);
    checkOutput("r5_aEXE", {27'd0, waddrExe}, 32'd5);
    checkOutput("r5_idIdle", {31'd0, writeId}, 32'd0);
    tick();
    checkOutput("r5_wMEM", {31'd0, writeMem}, 32'd1);
    checkOutput("r5_aMEM", {27'd0, waddrMem}, 32'd5);
    tick();
    checkOutput("r5_wbWen", {31'd0, wbWen}, 32'd1);
    checkOutput("r5_wbA", {27'd0, wbWaddr}, 32'd5);
    tick();
    checkOutput("r5_wbGone", {31'd0, wbWen}, 32'd0);

    // Register 0 is never recorded as a write.
    applyStimulus(1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("r0_wID", {31'd0, writeId}, 32'd0);
    tick();
    checkOutput("r0_wEXE", {31'd0, writeExe}, 32'd0);
    tick();
    checkOutput("r0_wMEM", {31'd0, writeMem}, 32'd0);
    tick();
    checkOutput("r0_wbWen", {31'd0, wbWen}, 32'd0);

    // $7 then $8 held off by a two-cycle stall.
    resetDut();
    applyStimulus(1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    checkOutput("st_aID7", {27'd0, waddrId}, 32'd7);
    applyStimulus(1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
    tick();
    checkOutput("st_wID_b1", {31'd0, writeId}, 32'd0);
    checkOutput("st_wEXE7", {31'd0, writeExe}, 32'd1);
    checkOutput("st_aEXE7", {27'd0, waddrExe}, 32'd7);
    tick();
    checkOutput("st_wID_b2", {31'd0, writeId}, 32'd0);
    checkOutput("st_wEXE_b1", {31'd0, writeExe}, 32'd0);
    checkOutput("st_aMEM7", {27'd0, waddrMem}, 32'd7);
    checkOutput("st_wMEM7", {31'd0, writeMem}, 32'd1);
    applyStimulus(1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("st_wID8", {31'd0, writeId}, 32'd1);
    checkOutput("st_aID8", {27'd0, waddrId}, 32'd8);
    checkOutput("st_wb7", {27'd0, wbWaddr}, 32'd7);
    checkOutput("st_wbWen7", {31'd0, wbWen}, 32'd1);
    checkOutput("st_wMEM_b", {31'd0, writeMem}, 32'd0);
    checkOutput("st_sCnt", {16'd0, stallCnt}, 32'd2);
    checkOutput("st_bCnt", {16'd0, bubbleCnt}, 32'd2);
    checkOutput("st_err", {31'd0, stallErr}, 32'd0);

    // Stall and flush together on $9: a single bubble, both counters step.
    resetDut();
    applyStimulus(1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("sf_wID", {31'd0, writeId}, 32'd0);
    checkOutput("sf_aID", {27'd0, waddrId}, 32'd0);
    checkOutput("sf_sCnt", {16'd0, stallCnt}, 32'd1);
    checkOutput("sf_bCnt", {16'd0, bubbleCnt}, 32'd1);
    tick();
    checkOutput("sf_wEXE", {31'd0, writeExe}, 32'd0);
    tick();
    checkOutput("sf_wMEM", {31'd0, writeMem}, 32'd0);
    tick();
    checkOutput("sf_wbWen", {31'd0, wbWen}, 32'd0);

    // Flush alone drops the issue and counts a bubble but not a stall.
    applyStimulus(1'b1, 1'b1, 5'd10, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("fl_wID", {31'd0, writeId}, 32'd0);
    checkOutput("fl_sCnt", {16'd0, stallCnt}, 32'd1);
    checkOutput("fl_bCnt", {16'd0, bubbleCnt}, 32'd2);

    // Four-cycle stall run trips the sticky error flag.
    resetDut();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("run_err3", {31'd0, stallErr}, 32'd0);
    tick();
    checkOutput("run_err4", {31'd0, stallErr}, 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    checkOutput("run_errHold", {31'd0, stallErr}, 32'd1);
    checkOutput("run_sCnt", {16'd0, stallCnt}, 32'd4);
    checkOutput("run_bCnt", {16'd0, bubbleCnt}, 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("run_errRst", {31'd0, stallErr}, 32'd0);
    rst_n = 1'b1;

    // Three live records, then an asynchronous reset pulse between edges.
    resetDut();
    applyStimulus(1'b1, 1'b1, 5'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd2, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    checkOutput("mid_aID", {27'd0, waddrId}, 32'd3);
    checkOutput("mid_aEXE", {27'd0, waddrExe}, 32'd2);
    checkOutput("mid_aMEM", {27'd0, waddrMem}, 32'd1);
    checkOutput("mid_wMEM", {31'd0, writeMem}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midRst");
    rst_n = 1'b1;

    // Saturation of the stall counter.
    resetDut();
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    repeat (65535) tick();
    checkOutput("sat_full", {16'd0, stallCnt}, 32'h0000FFFF);
    tick();
    checkOutput("sat_hold", {16'd0, stallCnt}, 32'h0000FFFF);
    checkOutput("sat_bCnt", {16'd0, bubbleCnt}, 32'd0);
    checkOutput("sat_err", {31'd0, stallErr}, 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
